// File: rtl/croc_irq_pkg.sv
// Shared definitions for the interrupt aggregator: register map, decode enum
// and small bus helpers.
package croc_irq_pkg;

    localparam int unsigned MaxIrqs = 32;

    localparam logic [4:0] IrqPendingOffset = 5'h00;
    localparam logic [4:0] IrqEnableOffset  = 5'h04;
    localparam logic [4:0] IrqEdgeOffset    = 5'h08;
    localparam logic [4:0] IrqSetOffset     = 5'h0C;
    localparam logic [4:0] IrqActiveOffset  = 5'h10;

    typedef enum logic [2:0] {
        RegPending,
        RegEnable,
        RegEdge,
        RegSet,
        RegActive,
        RegInvalid
    } reg_sel_e;

    function automatic reg_sel_e decode_reg(input logic [2:0] word_idx);
        logic [4:0] offset;
        offset = {word_idx, 2'b00};
        case (offset)
            IrqPendingOffset: return RegPending;
            IrqEnableOffset:  return RegEnable;
            IrqEdgeOffset:    return RegEdge;
            IrqSetOffset:     return RegSet;
            IrqActiveOffset:  return RegActive;
            default:          return RegInvalid;
        endcase
    endfunction

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) begin
            mask[8*b +: 8] = {8{be[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchroniser for a vector of independent asynchronous inputs.
module irq_sync #(
    parameter int unsigned Width  = 1,
    parameter int unsigned Stages = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] async_i,
    output logic [Width-1:0] sync_o
);

    logic [Stages-1:0][Width-1:0] r_sync;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[Stages-2:0], async_i};
        end
    end

    assign sync_o = r_sync[Stages-1];

endmodule

// File: rtl/core_irq_ctrl.sv
// Interrupt aggregator: synchronises sources, latches level/edge pending state,
// masks with ENABLE and drives the core fast and external interrupt lines.
module core_irq_ctrl
    import croc_irq_pkg::*;
#(
    parameter int unsigned NumIrqs     = 16,
    parameter int unsigned NumFastIrqs = 16,
    parameter int unsigned SyncStages  = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumIrqs-1:0]     irqs_i,
    input  logic                   reg_req_i,
    output logic                   reg_gnt_o,
    input  logic                   reg_we_i,
    input  logic [3:0]             reg_be_i,
    input  logic [31:0]            reg_addr_i,
    input  logic [31:0]            reg_wdata_i,
    output logic                   reg_rvalid_o,
    output logic [31:0]            reg_rdata_o,
    output logic                   reg_err_o,
    output logic [NumFastIrqs-1:0] fast_irq_o,
    output logic                   ext_irq_o
);

    if (NumIrqs == 0 || NumIrqs > MaxIrqs) begin : g_bad_num_irqs
        $fatal(1, "NumIrqs must be in 1..32");
    end
    if (NumFastIrqs == 0 || NumFastIrqs > 16 || NumFastIrqs > NumIrqs) begin : g_bad_num_fast
        $fatal(1, "NumFastIrqs must be in 1..16 and not exceed NumIrqs");
    end
    if (SyncStages < 2) begin : g_bad_sync_stages
        $fatal(1, "SyncStages must be at least 2");
    end

    // Registers are kept MaxIrqs wide; bits at or above NumIrqs are held at 0.
    localparam logic [MaxIrqs-1:0] ValidMask = {MaxIrqs{1'b1}} >> (MaxIrqs - NumIrqs);
    localparam logic [MaxIrqs-1:0] FastMask  = {MaxIrqs{1'b1}} >> (MaxIrqs - NumFastIrqs);

    logic [MaxIrqs-1:0]     r_pending;
    logic [MaxIrqs-1:0]     r_enable;
    logic [MaxIrqs-1:0]     r_edge;
    logic [MaxIrqs-1:0]     r_prev;
    logic [NumFastIrqs-1:0] r_fast;
    logic                   r_ext;
    logic                   r_rvalid;
    logic [31:0]            r_rdata;
    logic                   r_err;

    logic [NumIrqs-1:0]     w_sync_raw;
    logic [MaxIrqs-1:0]     w_sync;
    reg_sel_e               w_sel;
    logic                   w_err;
    logic                   w_wr;
    logic [31:0]            w_be_mask;
    logic [MaxIrqs-1:0]     w_wdata;
    logic [MaxIrqs-1:0]     w_enable_next;
    logic [MaxIrqs-1:0]     w_edge_next;
    logic [MaxIrqs-1:0]     w_edge_chg;
    logic [MaxIrqs-1:0]     w_w1c;
    logic [MaxIrqs-1:0]     w_w1s;
    logic [MaxIrqs-1:0]     w_rise;
    logic [MaxIrqs-1:0]     w_edge_pend;
    logic [MaxIrqs-1:0]     w_pend_next;
    logic [MaxIrqs-1:0]     w_active;
    logic [31:0]            w_rdata;
    logic                   w_unused_addr;

    irq_sync #(
        .Width  (NumIrqs),
        .Stages (SyncStages)
    ) u_irq_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i (irqs_i),
        .sync_o  (w_sync_raw)
    );

    always_comb begin
        w_sync                = '0;
        w_sync[NumIrqs-1:0]   = w_sync_raw;
    end

    assign w_unused_addr = ^{reg_addr_i[31:5], reg_addr_i[1:0]};

    assign w_sel     = decode_reg(reg_addr_i[4:2]);
    assign w_err     = reg_req_i && (w_sel == RegInvalid || (reg_we_i && w_sel == RegActive));
    assign w_wr      = reg_req_i && reg_we_i && !w_err;
    assign w_be_mask = be_to_mask(reg_be_i);
    assign w_wdata   = reg_wdata_i & w_be_mask & ValidMask;

    assign w_enable_next = (w_wr && w_sel == RegEnable) ? ((r_enable & ~w_be_mask) | w_wdata) : r_enable;
    assign w_edge_next   = (w_wr && w_sel == RegEdge)   ? ((r_edge   & ~w_be_mask) | w_wdata) : r_edge;
    assign w_edge_chg    = r_edge ^ w_edge_next;

    assign w_w1c = (w_wr && w_sel == RegPending) ? w_wdata : '0;
    assign w_w1s = (w_wr && w_sel == RegSet)     ? w_wdata : '0;

    // Edge channels: a new edge or a software set beats a same-cycle clear.
    assign w_rise      = w_sync & ~r_prev;
    assign w_edge_pend = (r_pending & ~w_w1c) | w_rise | w_w1s;

    // A mode change wipes the bit; otherwise level bits track the synced input.
    assign w_pend_next = ~w_edge_chg & ((r_edge & w_edge_pend) | (~r_edge & w_sync));

    assign w_active = r_pending & r_enable;

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_rdata = '0;
        if (reg_req_i && !reg_we_i && !w_err) begin
            case (w_sel)
                RegPending: w_rdata = r_pending;
                RegEnable:  w_rdata = r_enable;
                RegEdge:    w_rdata = r_edge;
                RegActive:  w_rdata = w_active;
                default:    w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending <= '0;
            r_enable  <= '0;
            r_edge    <= '0;
            r_prev    <= '0;
            r_fast    <= '0;
            r_ext     <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_pending <= w_pend_next;
            r_enable  <= w_enable_next;
            r_edge    <= w_edge_next;
            r_prev    <= w_sync;
            r_fast    <= w_active[NumFastIrqs-1:0];
            r_ext     <= |(w_active & ~FastMask);
            r_rvalid  <= reg_req_i;
            r_rdata   <= w_rdata;
            r_err     <= w_err;
        end
    end

    assign reg_gnt_o    = reg_req_i;
    assign reg_rvalid_o = r_rvalid;
    assign reg_rdata_o  = r_rdata;
    assign reg_err_o    = r_err;
    assign fast_irq_o   = r_fast;
    assign ext_irq_o    = r_ext;

endmodule

// File: tb/tb_core_irq_ctrl.sv
// Self-checking bench for core_irq_ctrl with 20 sources, 16 of them fast:
// directed scenarios with literal expectations plus a randomized phase.
module tb_core_irq_ctrl;

    localparam int unsigned NIrq  = 20;
    localparam int unsigned NFast = 16;
    localparam int unsigned NSync = 2;
    localparam logic [31:0] Valid = (32'd1 << NIrq) - 32'd1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NIrq-1:0]  irqs = '0;
    logic             req = 1'b0;
    logic             we = 1'b0;
    logic [3:0]       be = '0;
    logic [31:0]      addr = '0;
    logic [31:0]      wdata = '0;
    logic             gnt;
    logic             rvalid;
    logic [31:0]      rdata;
    logic             err;
    logic [NFast-1:0] fast;
    logic             ext;

    int checks = 0;
    int failures = 0;
    bit cmp_on = 1'b0;

    core_irq_ctrl #(
        .NumIrqs     (NIrq),
        .NumFastIrqs (NFast),
        .SyncStages  (NSync)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .irqs_i       (irqs),
        .reg_req_i    (req),
        .reg_gnt_o    (gnt),
        .reg_we_i     (we),
        .reg_be_i     (be),
        .reg_addr_i   (addr),
        .reg_wdata_i  (wdata),
        .reg_rvalid_o (rvalid),
        .reg_rdata_o  (rdata),
        .reg_err_o    (err),
        .fast_irq_o   (fast),
        .ext_irq_o    (ext)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // hist[k] is the raw input seen k+1 edges ago; the synchroniser output is
    // the input from NSync edges back, and its one-cycle-older copy is hist[NSync].
    logic [NIrq-1:0] m_hist [0:NSync];
    logic [31:0]     m_pending, m_enable, m_edge;
    logic [NFast-1:0] m_fast;
    logic            m_ext, m_rvalid, m_err;
    logic [31:0]     m_rdata;

    logic [31:0]     n_pending, n_enable, n_edge, n_rdata, n_act;
    logic            n_err;

    always_comb begin
        logic [31:0] sync_v, prev_v, bem, wd, w1s, w1c;
        int          idx;
        logic        wr;
        n_pending = m_pending;
        n_enable  = m_enable;
        n_edge    = m_edge;
        n_rdata   = '0;
        n_err     = 1'b0;
        n_act     = m_pending & m_enable;
        sync_v    = 32'(m_hist[NSync-1]);
        prev_v    = 32'(m_hist[NSync]);
        idx       = int'(addr[4:2]);
        n_err     = req && (idx > 4 || (we && idx == 4));
        wr        = req && we && !n_err;
        for (int b = 0; b < 4; b++) bem[8*b +: 8] = be[b] ? 8'hFF : 8'h00;
        wd  = wdata & bem & Valid;
        w1c = (wr && idx == 0) ? wd : 32'd0;
        w1s = (wr && idx == 3) ? wd : 32'd0;
        if (wr && idx == 1) n_enable = (m_enable & ~bem) | wd;
        if (wr && idx == 2) n_edge   = (m_edge & ~bem) | wd;
        for (int i = 0; i < int'(NIrq); i++) begin
            if (n_edge[i] != m_edge[i])       n_pending[i] = 1'b0;
            else if (!m_edge[i])              n_pending[i] = sync_v[i];
            else if ((sync_v[i] && !prev_v[i]) || w1s[i]) n_pending[i] = 1'b1;
            else if (w1c[i])                  n_pending[i] = 1'b0;
        end
        if (req && !we && !n_err) begin
            case (idx)
                0: n_rdata = m_pending;
                1: n_rdata = m_enable;
                2: n_rdata = m_edge;
                4: n_rdata = n_act;
                default: n_rdata = '0;
            endcase
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= int'(NSync); k++) m_hist[k] <= '0;
            m_pending <= '0; m_enable <= '0; m_edge <= '0;
            m_fast <= '0; m_ext <= 1'b0; m_rvalid <= 1'b0; m_rdata <= '0; m_err <= 1'b0;
        end else begin
            m_hist[0] <= irqs;
            for (int k = 1; k <= int'(NSync); k++) m_hist[k] <= m_hist[k-1];
            m_pending <= n_pending;
            m_enable  <= n_enable;
            m_edge    <= n_edge;
            m_fast    <= n_act[NFast-1:0];
            m_ext     <= |n_act[NIrq-1:NFast];
            m_rvalid  <= req;
            m_rdata   <= n_rdata;
            m_err     <= n_err;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && cmp_on) begin
            check("gnt", 32'(gnt), 32'(req));
            check("rvalid", 32'(rvalid), 32'(m_rvalid));
            if (m_rvalid) begin
                check("rdata", rdata, m_rdata);
                check("err", 32'(err), 32'(m_err));
            end
            check("fast_irq", 32'(fast), 32'(m_fast));
            check("ext_irq", 32'(ext), 32'(m_ext));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, output logic [31:0] rd_v, output logic er_v);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        @(negedge clk);
        check("bus_rvalid", 32'(rvalid), 32'd1);
        rd_v = rdata;
        er_v = err;
        #1;
        req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rv;
        logic        ev;
        bus(1'b1, a, 4'hF, d, rv, ev);
        check("wr_rdata", rv, 32'd0);
        check("wr_err", 32'(ev), 32'd0);
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rv;
        logic        ev;
        bus(1'b0, a, 4'hF, 32'd0, rv, ev);
        check(name, rv, exp);
        check({name, "_err"}, 32'(ev), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rv;
        logic        ev;

        step(3);
        rst_n = 1'b1;
        cmp_on = 1'b1;

        // Reset state
        check("rst_fast", 32'(fast), 32'd0);
        check("rst_ext", 32'(ext), 32'd0);
        rd("rst_pending", 32'h00, 32'd0);
        rd("rst_enable", 32'h04, 32'd0);
        rd("rst_edge", 32'h08, 32'd0);

        // Level channel latency, W1C ignored while high
        wr(32'h04, 32'h1);
        irqs[0] = 1'b1;
        step(3);
        check("lvl_rise_e2", 32'(fast[0]), 32'd0);
        step(1);
        check("lvl_rise_e3", 32'(fast[0]), 32'd1);
        wr(32'h00, 32'h1);
        rd("lvl_w1c_ignored", 32'h00, 32'h1);
        irqs[0] = 1'b0;
        step(3);
        check("lvl_fall_e2", 32'(fast[0]), 32'd1);
        step(1);
        check("lvl_fall_e3", 32'(fast[0]), 32'd0);

        // Edge channel: pulse latches, same-cycle edge beats W1C, W1C clears
        wr(32'h08, 32'h4);
        wr(32'h04, 32'h4);
        irqs[2] = 1'b1;
        step(2);
        irqs[2] = 1'b0;
        step(6);
        rd("edge_latched", 32'h00, 32'h4);
        check("edge_fast", 32'(fast[2]), 32'd1);
        irqs[2] = 1'b1;
        step(2);
        wr(32'h00, 32'h4);
        rd("edge_set_wins", 32'h00, 32'h4);
        irqs[2] = 1'b0;
        step(4);
        wr(32'h00, 32'h4);
        check("w1c_fall_g1", 32'(fast[2]), 32'd1);
        step(1);
        check("w1c_fall_g2", 32'(fast[2]), 32'd0);
        rd("w1c_cleared", 32'h00, 32'h0);

        // Channels above the fast range feed ext_irq
        wr(32'h04, 32'hFFFF_FFFF);
        rd("enable_upper_ignored", 32'h04, 32'h000F_FFFF);
        wr(32'h08, 32'h0004_0000);
        wr(32'h0C, 32'h0004_0000);
        step(1);
        check("ext_set", 32'(ext), 32'd1);
        check("ext_fast_zero", 32'(fast), 32'd0);
        rd("active_read", 32'h10, 32'h0004_0000);
        rd("set_reads_zero", 32'h0C, 32'h0);

        // Bus errors and byte enables
        bus(1'b1, 32'h10, 4'hF, 32'hF_FFFF, rv, ev);
        check("err_wr_active", 32'(ev), 32'd1);
        check("err_wr_active_rdata", rv, 32'd0);
        bus(1'b0, 32'h18, 4'hF, 32'd0, rv, ev);
        check("err_rd_18", 32'(ev), 32'd1);
        check("err_rd_18_rdata", rv, 32'd0);
        rd("enable_after_err", 32'h04, 32'h000F_FFFF);
        rd("active_after_err", 32'h10, 32'h0004_0000);
        wr(32'h04, 32'h0);
        bus(1'b1, 32'h04, 4'b0001, 32'hFFFF_FFFF, rv, ev);
        check("be_wr_err", 32'(ev), 32'd0);
        rd("be_byte0", 32'h04, 32'h0000_00FF);

        // Reset in the middle of an access
        wr(32'h08, 32'hF);
        wr(32'h04, 32'hF);
        wr(32'h0C, 32'hF);
        step(1);
        check("pre_rst_fast", 32'(fast), 32'hF);
        irqs[1] = 1'b1;
        step(1);
        req = 1'b1; we = 1'b0; addr = 32'h0; be = 4'hF;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_fast", 32'(fast), 32'd0);
        check("rst_async_ext", 32'(ext), 32'd0);
        check("rst_async_rvalid", 32'(rvalid), 32'd0);
        @(negedge clk);
        check("rst_no_rvalid", 32'(rvalid), 32'd0);
        #1;
        req = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(4);
        rd("post_rst_edge", 32'h08, 32'h0);
        rd("post_rst_level", 32'h00, 32'h2);
        wr(32'h08, 32'h2);
        step(4);
        rd("mode_change_no_edge", 32'h00, 32'h0);

        // Randomized phase against the model
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0)
                irqs = irqs ^ (NIrq'(1) << $urandom_range(0, NIrq - 1));
            if ($urandom_range(0, 9) < 6) begin
                req   = 1'b1;
                we    = 1'($urandom_range(0, 1));
                addr  = {27'($urandom), ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4))
                                                                   : 3'($urandom_range(5, 7)),
                         2'($urandom)};
                be    = 4'($urandom);
                wdata = $urandom;
            end else begin
                req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
            end
            step(1);
        end
        req = 1'b0; we = 1'b0;
        step(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
